// File: rtl/tilt_pkg.sv
// Shared tilt-pipeline definitions: Q1.14 format constants, divider FSM states
// and the signed Q1.14 word used by the divider, atan and rad-to-degree stages.
package tilt_pkg;
  localparam int Q_FRAC  = 14;
  localparam int ONE_Q14 = 16384;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    DONE
  } div_state_e;

  typedef logic signed [15:0] q1_14_t;
endpackage

// File: rtl/tilt_ratio_div_if.sv
// Operand/result handshake bundle of the tilt ratio divider.
interface tilt_ratio_div_if
  import tilt_pkg::*;
#(
  parameter int IN_W = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic signed [IN_W-1:0] num;
  logic signed [IN_W-1:0] den;
  logic                   out_valid;
  logic                   out_ready;
  q1_14_t                 ratio;
  logic                   swapped;
  logic                   num_neg;
  logic                   den_neg;
  logic                   div_zero;

  modport slave (
    input  in_valid, num, den, out_ready,
    output in_ready, out_valid, ratio, swapped, num_neg, den_neg, div_zero
  );

  modport master (
    output in_valid, num, den, out_ready,
    input  in_ready, out_valid, ratio, swapped, num_neg, den_neg, div_zero
  );
endinterface

// File: rtl/tilt_ratio_div_udiv_step.sv
// One restoring-division step: subtract the divisor when it fits and emit the quotient bit.
module tilt_udiv_step #(
  parameter int RW = 18
) (
  input  logic [RW-1:0] rem_i,
  input  logic [RW-1:0] div_i,
  output logic [RW-1:0] rem_o,
  output logic          qbit_o
);
  always_comb begin
    qbit_o = (rem_i >= div_i);
    rem_o  = qbit_o ? (rem_i - div_i) : rem_i;
  end
endmodule

// File: rtl/tilt_ratio_div.sv
// Sequential |num|/|den| divider producing a Q1.FRAC ratio of magnitude <= 1.0 for the atan stage.
// Define TILT_DIV_ROUND_EN to compute one extra quotient bit and round half-up (latency +1).
module tilt_ratio_div
  import tilt_pkg::*;
#(
  parameter int IN_W = 16,
  parameter int FRAC = Q_FRAC
) (
  input  logic         clk,
  input  logic         rst_n,
  tilt_ratio_div_if.slave bus
);
`ifdef TILT_DIV_ROUND_EN
  localparam int ITER = FRAC + 2;
`else
  localparam int ITER = FRAC + 1;
`endif
  localparam int MW = IN_W + 1;
  localparam int RW = IN_W + 2;
  localparam int CW = $clog2(ITER + 2);

  div_state_e     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [RW-1:0]  rem_q, rem_d;
  logic [RW-1:0]  dvs_q, dvs_d;
  logic [ITER-1:0] quo_q, quo_d;
  q1_14_t         ratio_q, ratio_d;
  logic           swapped_q, swapped_d;
  logic           num_neg_q, num_neg_d;
  logic           den_neg_q, den_neg_d;
  logic           zero_q, zero_d;

  logic signed [MW-1:0] num_x, den_x;
  logic        [MW-1:0] num_mag, den_mag;
  logic        [RW-1:0] step_rem;
  logic                 step_q;

  // Magnitudes carry one extra bit so the most negative input has a representable absolute value.
  assign num_x   = MW'(bus.num);
  assign den_x   = MW'(bus.den);
  assign num_mag = num_x[MW-1] ? $unsigned(-num_x) : $unsigned(num_x);
  assign den_mag = den_x[MW-1] ? $unsigned(-den_x) : $unsigned(den_x);

  tilt_udiv_step #(.RW(RW)) u_step (
    .rem_i  (rem_q),
    .div_i  (dvs_q),
    .rem_o  (step_rem),
    .qbit_o (step_q)
  );

  function automatic q1_14_t shape_ratio(input logic [ITER-1:0] q, input logic neg,
                                         input logic zero);
    logic [FRAC:0] mag;
`ifdef TILT_DIV_ROUND_EN
    mag = q[ITER-1:1] + (FRAC+1)'(q[0]);
`else
    mag = q;
`endif
    if (zero) mag = '0;
    return neg ? -q1_14_t'(mag) : q1_14_t'(mag);
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    quo_d     = quo_q;
    ratio_d   = ratio_q;
    swapped_d = swapped_q;
    num_neg_d = num_neg_q;
    den_neg_d = den_neg_q;
    zero_d    = zero_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          swapped_d = (num_mag > den_mag);
          num_neg_d = bus.num[IN_W-1];
          den_neg_d = bus.den[IN_W-1];
          zero_d    = (num_mag == '0) && (den_mag == '0);
          rem_d     = RW'(swapped_d ? den_mag : num_mag);
          dvs_d     = RW'(swapped_d ? num_mag : den_mag);
          quo_d     = '0;
          cnt_d     = '0;
          state_d   = DIVIDE;
        end
      end
      DIVIDE: begin
        // The counter runs one past the last iteration so the result is registered before DONE.
        if (cnt_q < CW'(ITER)) begin
          rem_d = step_rem << 1;
          quo_d = {quo_q[ITER-2:0], step_q};
          cnt_d = cnt_q + CW'(1);
        end else begin
          ratio_d = shape_ratio(quo_q, num_neg_q ^ den_neg_q, zero_q);
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ratio_q   <= '0;
      swapped_q <= 1'b0;
      num_neg_q <= 1'b0;
      den_neg_q <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ratio_q   <= ratio_d;
      swapped_q <= swapped_d;
      num_neg_q <= num_neg_d;
      den_neg_q <= den_neg_d;
      zero_q    <= zero_d;
    end
  end

  always_ff @(posedge clk) begin
    rem_q <= rem_d;
    dvs_q <= dvs_d;
    quo_q <= quo_d;
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.ratio     = ratio_q;
  assign bus.swapped   = swapped_q;
  assign bus.num_neg   = num_neg_q;
  assign bus.den_neg   = den_neg_q;
  assign bus.div_zero  = zero_q;
endmodule
